// File: rtl/dm_arbiter.sv
// Two-port arbiter for the shared 128x8 data memory: port A (SPI slave) has fixed
// priority, port B is protected from starvation by an aging counter.
module dm_arbiter #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WAIT_W   = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              owner
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t              state, state_n;
  logic [WAIT_W-1:0]   wait_cnt, wait_n;
  logic [ADDR_W-1:0]   mem_addr_n;
  logic [DATA_W-1:0]   mem_din_n;
  logic                mem_we_n;
  logic                busy_n;
  logic                owner_n;
  logic                a_ack_n;
  logic                b_ack_n;
  logic                grant_b;

  // State and all output registers; the memory-side registers double as the request latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
      busy     <= 1'b0;
      owner    <= 1'b0;
      a_ack    <= 1'b0;
      b_ack    <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_n;
      mem_addr <= mem_addr_n;
      mem_din  <= mem_din_n;
      mem_we   <= mem_we_n;
      busy     <= busy_n;
      owner    <= owner_n;
      a_ack    <= a_ack_n;
      b_ack    <= b_ack_n;
    end
  end

  // Next-state, grant decision and next values of the registered outputs.
  always_comb begin
    state_n    = state;
    wait_n     = wait_cnt;
    mem_addr_n = mem_addr;
    mem_din_n  = mem_din;
    mem_we_n   = 1'b0;
    busy_n     = 1'b0;
    owner_n    = owner;
    a_ack_n    = 1'b0;
    b_ack_n    = 1'b0;
    grant_b    = 1'b0;

    case (state)
      IDLE: begin
        if (a_req || b_req) begin
          grant_b  = b_req && (!a_req || (wait_cnt == WAIT_MAX));
          owner_n  = grant_b;
          state_n  = ACCESS;
          busy_n   = 1'b1;
          if (grant_b) begin
            mem_addr_n = b_addr;
            mem_din_n  = b_wdata;
            mem_we_n   = b_we;
            wait_n     = '0;
          end else begin
            mem_addr_n = a_addr;
            mem_din_n  = a_wdata;
            mem_we_n   = a_we;
            if (b_req && (wait_cnt != WAIT_MAX)) begin
              wait_n = wait_cnt + WAIT_W'(1);
            end
          end
        end
      end
      ACCESS: begin
        state_n = RESP;
        busy_n  = 1'b1;
        a_ack_n = !owner;
        b_ack_n = owner;
      end
      RESP: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // B withdrawing its request forfeits any accumulated age.
    if (!b_req) begin
      wait_n = '0;
    end
  end

  // Synchronous-read memory data arrives during RESP, exactly when ack is high.
  assign a_rdata = a_ack ? mem_dout : '0;
  assign b_rdata = b_ack ? mem_dout : '0;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter with a behavioural sync-read 128x8 memory
// and a queue of expected responses per access.
module tb_dm_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       a_req, a_we, b_req, b_we;
  logic [6:0] a_addr, b_addr;
  logic [7:0] a_wdata, b_wdata;
  logic       a_ack, b_ack;
  logic [7:0] a_rdata, b_rdata;
  logic [6:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_din;
  logic [7:0] mem_dout;
  logic       busy, owner;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic       port;
    logic [7:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] mem [128];
  int we_total = 0;
  int a_ack_total = 0;
  int b_ack_total = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(7), .DATA_W(8), .MAX_WAIT(4), .WAIT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout),
    .busy(busy), .owner(owner)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_din;
    mem_dout <= mem[mem_addr];
  end

  always @(negedge clk) begin
    if (mem_we) we_total <= we_total + 1;
    if (a_ack)  a_ack_total <= a_ack_total + 1;
    if (b_ack)  b_ack_total <= b_ack_total + 1;
  end

  // Drives one request from a negedge and waits (bounded) for its ack; no checking here.
  task automatic run_access(input bit port, input bit we, input logic [6:0] addr,
                            input logic [7:0] wdata, output logic [7:0] rdata,
                            output int lat, output int we_at, output bit ok);
    ok = 1'b0; lat = 0; we_at = 0; rdata = 8'h00;
    if (port) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
    else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lat++;
      if (mem_we && we_at == 0) we_at = lat;
      if (port ? b_ack : a_ack) begin
        rdata = port ? b_rdata : a_rdata;
        ok = 1'b1;
        break;
      end
    end
    if (port) b_req = 1'b0; else a_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 7'h00; a_wdata = 8'h11;
    b_req = 1'b0; b_we = 1'b0; b_addr = 7'h00; b_wdata = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({mem_we, a_ack, b_ack, busy, owner} !== 5'b0) begin
      n_err++; $display("FAIL reset_ctrl: got we/aack/back/busy/owner=%b want 00000",
                        {mem_we, a_ack, b_ack, busy, owner});
    end
    n_cmp++;
    if ({mem_addr, mem_din, a_rdata, b_rdata} !== 31'h0) begin
      n_err++; $display("FAIL reset_data: got addr=%h din=%h ardata=%h brdata=%h want all 0",
                        mem_addr, mem_din, a_rdata, b_rdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({busy, owner, mem_we, mem_din} !== {1'b1, 1'b0, 1'b1, 8'h11}) begin
      n_err++; $display("FAIL reset_first_grant: got busy=%b owner=%b we=%b din=%h want 1 0 1 11",
                        busy, owner, mem_we, mem_din);
    end
    @(negedge clk);
    n_cmp++;
    if (a_ack !== 1'b1) begin
      n_err++; $display("FAIL reset_first_ack: got a_ack=%b want 1", a_ack);
    end
    a_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read();
    logic [7:0] rd; int lat, we_at, we0, b0; bit ok; exp_t e;
    we0 = we_total; b0 = b_ack_total;
    run_access(1'b0, 1'b1, 7'h12, 8'h5A, rd, lat, we_at, ok);
    n_cmp++;
    if (!ok || lat != 2 || we_at != 1) begin
      n_err++; $display("FAIL a_write_timing: got ok=%0d ack_lat=%0d we_at=%0d want 1 2 1", ok, lat, we_at);
    end
    @(negedge clk);
    n_cmp++;
    if (we_total - we0 != 1) begin
      n_err++; $display("FAIL a_write_we_len: got %0d cycles of mem_we want 1", we_total - we0);
    end
    exp_q.push_back('{port: 1'b0, data: 8'h5A});
    run_access(1'b0, 1'b0, 7'h12, 8'h00, rd, lat, we_at, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || lat != 2 || rd !== e.data || we_at != 0) begin
      n_err++; $display("FAIL a_read: got ok=%0d lat=%0d rdata=%h we_at=%0d want 1 2 %h 0",
                        ok, lat, rd, we_at, e.data);
    end
    @(negedge clk);
    n_cmp++;
    if (b_ack_total != b0) begin
      n_err++; $display("FAIL a_only_b_ack: got %0d b_acks want 0", b_ack_total - b0);
    end
  endtask

  task automatic test_port_b();
    logic [7:0] rd; int lat, we_at; bit ok; exp_t e;
    run_access(1'b0, 1'b1, 7'h7F, 8'hC3, rd, lat, we_at, ok);
    @(negedge clk);
    exp_q.push_back('{port: 1'b1, data: 8'hC3});
    run_access(1'b1, 1'b0, 7'h7F, 8'h00, rd, lat, we_at, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || lat != 2 || rd !== e.data || owner !== e.port || a_ack !== 1'b0) begin
      n_err++; $display("FAIL b_read_7f: got ok=%0d lat=%0d rdata=%h owner=%b a_ack=%b want 1 2 %h 1 0",
                        ok, lat, rd, owner, a_ack, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_aging();
    exp_t e; int got, last, cyc; bit seen_both;
    got = 0; last = 0; seen_both = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back('{port: ((i % 5) == 4), data: ((i % 5) == 4) ? 8'hC3 : 8'h5A});
    end
    a_we = 1'b0; a_addr = 7'h12; b_we = 1'b0; b_addr = 7'h7F;
    a_req = 1'b1; b_req = 1'b1;
    for (cyc = 1; cyc <= 60 && got < 10; cyc++) begin
      @(negedge clk);
      if (a_ack && b_ack) seen_both = 1'b1;
      if (a_ack || b_ack) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (b_ack !== e.port || (b_ack ? b_rdata : a_rdata) !== e.data) begin
          n_err++; $display("FAIL aging_grant%0d: got port=%b rdata=%h want port=%b rdata=%h",
                            got, b_ack, b_ack ? b_rdata : a_rdata, e.port, e.data);
        end
        if (got > 0) begin
          n_cmp++;
          if (cyc - last != 3) begin
            n_err++; $display("FAIL aging_spacing%0d: got %0d cycles between acks want 3", got, cyc - last);
          end
        end
        last = cyc;
        got++;
      end
    end
    a_req = 1'b0; b_req = 1'b0;
    n_cmp++;
    if (got != 10 || seen_both) begin
      n_err++; $display("FAIL aging_count: got %0d acks both=%b want 10 0", got, seen_both);
    end
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [7:0] rd; int lat, we_at, a0; bit ok; exp_t e;
    run_access(1'b0, 1'b1, 7'h05, 8'h3C, rd, lat, we_at, ok);
    @(negedge clk);
    a0 = a_ack_total;
    a_req = 1'b1; a_we = 1'b1; a_addr = 7'h05; a_wdata = 8'hFF;
    @(negedge clk);
    n_cmp++;
    if (mem_we !== 1'b1) begin
      n_err++; $display("FAIL rstmid_access: got mem_we=%b want 1 before reset", mem_we);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rstmid_async: got mem_we=%b busy=%b want 0 0", mem_we, busy);
    end
    a_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (a_ack_total != a0) begin
      n_err++; $display("FAIL rstmid_no_ack: got %0d a_acks want 0", a_ack_total - a0);
    end
    exp_q.push_back('{port: 1'b0, data: 8'h3C});
    run_access(1'b0, 1'b0, 7'h05, 8'h00, rd, lat, we_at, ok);
    e = exp_q.pop_front();
    n_cmp++;
    if (!ok || rd !== e.data) begin
      n_err++; $display("FAIL rstmid_prior: got ok=%0d rdata=%h want 1 %h", ok, rd, e.data);
    end
    @(negedge clk);
  endtask

  task automatic test_idle_return();
    logic [7:0] rd; int lat, we_at, we0, a0, b0; bit ok, busy_seen;
    run_access(1'b0, 1'b0, 7'h12, 8'h00, rd, lat, we_at, ok);
    we0 = we_total; a0 = a_ack_total; b0 = b_ack_total; busy_seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0) busy_seen = 1'b1;
    end
    n_cmp++;
    if (busy_seen || we_total != we0 || a_ack_total != a0 + 1 || b_ack_total != b0) begin
      n_err++; $display("FAIL idle_return: got busy_seen=%b we=%0d a_acks=%0d b_acks=%0d want 0 0 1 0",
                        busy_seen, we_total - we0, a_ack_total - a0, b_ack_total - b0);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_port_b();
    test_aging();
    test_reset_mid();
    test_idle_return();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
